pipe_stage_reg: RTL and testbench

//   Parametrised inter-stage pipeline register, successor to the fixed ID/EX latch.

---
 rtl/pipe_stage_reg.sv | 69 ++++++
 tb/tb_pipe_stage_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall hold/bubble, flush,
// delay-slot feedback, saturating bubble/hold counters and sticky protocol error.
module pipe_stage_reg #(
   parameter int                  DATA_W    = 128,
   parameter int                  STALL_W   = 6,
   parameter int                  STAGE_IDX = 2,
   parameter logic [DATA_W-1:0]   NOP_VALUE = '0,
   parameter int                  CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_dslot_next,
   input  logic               cnt_clr,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_dslot_flag,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic               proto_err
);
   logic              up, dn, hold, bubble;
   logic              valid_q, valid_d, dslot_q, dslot_d, err_q, err_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  bub_q, bub_d, hold_q, hold_d;

   assign up     = stall[STAGE_IDX];
   assign dn     = stall[STAGE_IDX+1];
   assign hold   = up & dn & ~flush;
   assign bubble = up & ~dn & ~flush;

   // Bubble keeps the delay-slot flag so the slot status survives the stall.
   always_comb begin
      valid_d = hold ? valid_q : (flush | up) ? 1'b0 : in_valid;
      data_d  = hold ? data_q : (flush | up) ? NOP_VALUE : in_data;
      dslot_d = flush ? 1'b0 : up ? dslot_q : in_dslot_next;
      bub_d   = cnt_clr ? '0 : (bubble && bub_q != '1) ? bub_q + CNT_W'(1) : bub_q;
      hold_d  = cnt_clr ? '0 : (hold && hold_q != '1) ? hold_q + CNT_W'(1) : hold_q;
      err_d   = err_q | (~up & dn);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= NOP_VALUE;
         dslot_q <= 1'b0;
         bub_q   <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         dslot_q <= dslot_d;
         bub_q   <= bub_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_data       = data_q;
   assign out_dslot_flag = dslot_q;
   assign bubble_cnt     = bub_q;
   assign hold_cnt       = hold_q;
   assign proto_err      = err_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus against a behavioural model,
// driving a wide-counter instance and a 2-bit-counter instance in parallel.
module tb_pipe_stage_reg;
   localparam int DW = 128;
   localparam int SW = 6;
   localparam int SI = 2;
   localparam logic [DW-1:0] NOP = 128'h5A5A;

   logic          clk = 1'b0, rst = 1'b0;
   logic [SW-1:0] stall = '0;
   logic          flush = 1'b0, in_valid = 1'b0, in_dslot_next = 1'b0, cnt_clr = 1'b0;
   logic [DW-1:0] in_data = '0;

   logic          a_valid, a_dslot, a_err, b_valid, b_dslot, b_err;
   logic [DW-1:0] a_data, b_data;
   logic [15:0]   a_bub, a_hold;
   logic [1:0]    b_bub, b_hold;

   pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(SI), .NOP_VALUE(NOP), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_dslot_next(in_dslot_next), .cnt_clr(cnt_clr), .out_valid(a_valid), .out_data(a_data),
      .out_dslot_flag(a_dslot), .bubble_cnt(a_bub), .hold_cnt(a_hold), .proto_err(a_err));

   pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(SI), .NOP_VALUE(NOP), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_dslot_next(in_dslot_next), .cnt_clr(cnt_clr), .out_valid(b_valid), .out_data(b_data),
      .out_dslot_flag(b_dslot), .bubble_cnt(b_bub), .hold_cnt(b_hold), .proto_err(b_err));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   logic          m_valid, m_dslot, m_err;
   logic [DW-1:0] m_data;
   int            m_bub, m_hold;

   function automatic int sat(input int v, input int w);
      return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("valid", a_valid, m_valid);
      chk("data", a_data, m_data);
      chk("dslot", a_dslot, m_dslot);
      chk("bubble_cnt", a_bub, sat(m_bub, 16));
      chk("hold_cnt", a_hold, sat(m_hold, 16));
      chk("proto_err", a_err, m_err);
      chk("sat_valid", b_valid, m_valid);
      chk("sat_data", b_data, m_data);
      chk("sat_bubble_cnt", b_bub, sat(m_bub, 2));
      chk("sat_hold_cnt", b_hold, sat(m_hold, 2));
      chk("sat_proto_err", b_err, m_err);
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_data = NOP; m_dslot = 1'b0; m_err = 1'b0; m_bub = 0; m_hold = 0;
   endtask

   task automatic model_edge();
      logic up, dn;
      up = stall[SI];
      dn = stall[SI+1];
      if (flush) begin
         m_valid = 1'b0; m_data = NOP; m_dslot = 1'b0;
      end else if (up && !dn) begin
         m_valid = 1'b0; m_data = NOP;
      end else if (!up) begin
         m_valid = in_valid; m_data = in_data; m_dslot = in_dslot_next;
      end
      if (cnt_clr) begin
         m_bub = 0; m_hold = 0;
      end else if (!flush && up) begin
         if (dn) m_hold++;
         else m_bub++;
      end
      if (!up && dn) m_err = 1'b1;
   endtask

   task automatic cyc(input logic [SW-1:0] s, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic ds, input logic c);
      stall = s; flush = f; in_valid = v; in_data = d; in_dslot_next = ds; cnt_clr = c;
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      stall = 6'b001111;
      in_data = '1;
      rst = 1'b0;
      #1 model_reset();
      check_all();
      @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [SW-1:0] s;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;
      cyc(6'b000000, 0, 1, 128'h1234, 1, 1);
      chk("t2_valid", a_valid, 1'b1);
      chk("t2_data", a_data, 128'h1234);
      chk("t2_dslot", a_dslot, 1'b1);
      cyc(6'b000111, 0, 1, 128'h7777, 0, 0);
      chk("t3_data", a_data, NOP);
      chk("t3_dslot", a_dslot, 1'b1);
      chk("t3_bubble", a_bub, 16'd1);
      cyc(6'b000000, 0, 1, 128'hBEEF, 1, 0);
      repeat (3) cyc(6'b001111, 0, 0, 128'h1111, 0, 0);
      chk("t4_data", a_data, 128'hBEEF);
      chk("t4_hold", a_hold, 16'd3);
      chk("t4_bubble", a_bub, 16'd1);
      cyc(6'b001111, 1, 1, 128'h2222, 1, 0);
      chk("t5_valid", a_valid, 1'b0);
      chk("t5_data", a_data, NOP);
      chk("t5_dslot", a_dslot, 1'b0);
      chk("t5_hold", a_hold, 16'd3);
      cyc(6'b000000, 0, 1, 128'h3333, 1, 0);
      do_reset();
      cyc(6'b000000, 0, 0, 128'h0, 0, 1);
      repeat (5) cyc(6'b000111, 0, 1, 128'h4444, 0, 0);
      chk("t6_sat_bubble", b_bub, 2'd3);
      chk("t6_bubble", a_bub, 16'd5);
      cyc(6'b001000, 0, 1, 128'h5555, 0, 0);
      chk("t6_err", a_err, 1'b1);
      chk("t6_data", a_data, 128'h5555);
      cyc(6'b000000, 0, 1, 128'h6666, 0, 0);
      chk("t6_err_sticky", a_err, 1'b1);
      cyc(6'b000000, 0, 1, 128'h6666, 0, 1);
      chk("t6_clr_bubble", b_bub, 2'd0);
      chk("t6_clr_hold", a_hold, 16'd0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) do_reset();
         else begin
            s = SW'($urandom);
            if (!s[SI] && s[SI+1] && $urandom_range(0, 7) != 0) s[SI+1] = 1'b0;
            cyc(s, $urandom_range(0, 7) == 0, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                1'($urandom), $urandom_range(0, 15) == 0);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
